// File: rtl/debug_pkg.sv
// Shared definitions for the UART debug controller: FSM state encoding,
// default command bytes, frame header and the frame-length helper.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONT,
    ST_STEP,
    ST_ADVANCE,
    ST_CAPTURE,
    ST_SEND
  } state_e;

  localparam logic [7:0] DEF_HEADER    = 8'hA5;
  localparam logic [7:0] DEF_CMD_CONT  = 8'h63;  // 'c'
  localparam logic [7:0] DEF_CMD_STEP  = 8'h73;  // 's'
  localparam logic [7:0] DEF_CMD_NEXT  = 8'h6E;  // 'n'
  localparam logic [7:0] DEF_CMD_ABORT = 8'h71;  // 'q'

  // Header + cycle counter + snapshot + checksum.
  function automatic int frame_len(input int snap_bytes, input int cyc_bytes);
    return 1 + cyc_bytes + snap_bytes + 1;
  endfunction

endpackage

// File: rtl/debug_frame_tx.sv
// Frame serialiser: latches the snapshot on start, then walks the frame
// (header, cycle count LSB first, snapshot byte 0 first, XOR checksum) into
// the tx FIFO, pausing whenever the FIFO is full.
//
// Handshake: a byte is transferred on every cycle where wr_o=1; wr_o is only
// raised while active_i=1 and tx_full_i=0, and the index advances only then,
// so a full FIFO simply holds the current byte in place.
module debug_frame_tx import debug_pkg::*; #(
  parameter int         SNAP_BYTES = 55,
  parameter int         CYC_BYTES  = 2,
  parameter logic [7:0] HEADER     = DEF_HEADER
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    active_i,
  input  logic [SNAP_BYTES*8-1:0] snapshot_i,
  input  logic [CYC_BYTES*8-1:0]  cyc_count_i,
  input  logic                    tx_full_i,
  output logic                    wr_o,
  output logic [7:0]              data_o,
  output logic                    done_o
);

  localparam int FRAME_LEN = frame_len(SNAP_BYTES, CYC_BYTES);
  localparam int IDX_W     = $clog2(FRAME_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [SNAP_BYTES*8-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [7:0]              chk_q, chk_d;
  logic [FRAME_LEN*8-1:0]  frame_flat;
  logic [7:0]              cur_byte;
  logic                    push;

  // Byte k of the frame sits at bits [8k+7:8k].
  assign frame_flat = {chk_q, snap_q, cyc_count_i, HEADER};
  assign cur_byte   = 8'(frame_flat >> {idx_q, 3'b000});

  assign push   = active_i && !tx_full_i;
  assign wr_o   = push;
  assign data_o = active_i ? cur_byte : 8'h00;
  assign done_o = push && (idx_q == LAST_IDX);

  // Next-state for latch, index and running checksum (header excluded).
  always_comb begin
    snap_d = snap_q;
    idx_d  = idx_q;
    chk_d  = chk_q;
    if (start_i) begin
      snap_d = snapshot_i;
      idx_d  = '0;
      chk_d  = '0;
    end else if (push) begin
      idx_d = idx_q + 1'b1;
      if (idx_q != '0) chk_d = chk_q ^ cur_byte;
    end
  end

  // Serialiser registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_q <= '0;
      idx_q  <= '0;
      chk_q  <= '0;
    end else begin
      snap_q <= snap_d;
      idx_q  <= idx_d;
      chk_q  <= chk_d;
    end
  end

endmodule

// File: rtl/debug_unit_frame.sv
// UART debug controller for the pipelined datapath: runs the pipeline
// continuously or one cycle at a time on UART commands and, after every stop,
// emits a framed snapshot plus executed-cycle count via debug_frame_tx.
//
// Rx handshake: readFifoFlag pops the rx FIFO head in the same cycle it is
// raised, and it is raised whenever uartDataAvailable=1 in IDLE, CONT or STEP,
// so commands are consumed one per cycle.
module debug_unit_frame import debug_pkg::*; #(
  parameter int         SNAP_BYTES = 55,
  parameter int         CYC_BYTES  = 2,
  parameter logic [7:0] HEADER     = DEF_HEADER,
  parameter logic [7:0] CMD_CONT   = DEF_CMD_CONT,
  parameter logic [7:0] CMD_STEP   = DEF_CMD_STEP,
  parameter logic [7:0] CMD_NEXT   = DEF_CMD_NEXT,
  parameter logic [7:0] CMD_ABORT  = DEF_CMD_ABORT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    endOfProgram,
  input  logic [SNAP_BYTES*8-1:0] snapshot,
  input  logic [7:0]              uartFifoDataIn,
  input  logic                    uartDataAvailable,
  input  logic                    uartTxFull,
  output logic                    readFifoFlag,
  output logic [7:0]              dataToUartOutFifo,
  output logic                    writeFifoFlag,
  output logic                    pipeEnable,
  output logic                    pipeReset,
  output logic                    ledIdle,
  output logic                    ledCont,
  output logic                    ledStep,
  output logic                    ledSend,
  output state_e                  dbgState
);

  state_e                 state_q, state_d;
  logic                   done_q, done_d;
  logic [CYC_BYTES*8-1:0] cyc_q, cyc_d;
  logic                   tx_done;
  logic                   rx_abort;

  assign dbgState = state_q;
  assign rx_abort = uartDataAvailable && (uartFifoDataIn == CMD_ABORT);

  // Output decode and next-state from the registered state.
  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    readFifoFlag = 1'b0;
    pipeEnable   = 1'b0;
    pipeReset    = 1'b0;
    ledIdle      = 1'b0;
    ledCont      = 1'b0;
    ledStep      = 1'b0;
    ledSend      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pipeReset    = 1'b1;
        ledIdle      = 1'b1;
        done_d       = 1'b0;
        readFifoFlag = uartDataAvailable;
        if (uartDataAvailable) begin
          if (uartFifoDataIn == CMD_CONT)      state_d = ST_CONT;
          else if (uartFifoDataIn == CMD_STEP) state_d = ST_STEP;
        end
      end
      ST_CONT: begin
        pipeEnable   = 1'b1;
        ledCont      = 1'b1;
        readFifoFlag = uartDataAvailable;
        if (endOfProgram || rx_abort) begin
          done_d  = 1'b1;
          state_d = ST_CAPTURE;
        end
      end
      ST_STEP: begin
        ledStep      = 1'b1;
        readFifoFlag = uartDataAvailable;
        if (rx_abort) begin
          done_d  = 1'b1;
          state_d = ST_CAPTURE;
        end else if (uartDataAvailable && (uartFifoDataIn == CMD_NEXT)) begin
          state_d = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        pipeEnable = 1'b1;
        ledStep    = 1'b1;
        if (endOfProgram) done_d = 1'b1;
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        ledSend = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        ledSend = 1'b1;
        if (tx_done) state_d = done_q ? ST_IDLE : ST_STEP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Executed-cycle counter: saturating, cleared while idle.
  always_comb begin
    cyc_d = cyc_q;
    if (state_q == ST_IDLE)                 cyc_d = '0;
    else if (pipeEnable && (cyc_q != '1))   cyc_d = cyc_q + 1'b1;
  end

  // Controller state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cyc_q   <= cyc_d;
    end
  end

  debug_frame_tx #(
    .SNAP_BYTES (SNAP_BYTES),
    .CYC_BYTES  (CYC_BYTES),
    .HEADER     (HEADER)
  ) u_frame_tx (
    .clk_i       (clock),
    .rst_i       (reset),
    .start_i     (state_q == ST_CAPTURE),
    .active_i    (state_q == ST_SEND),
    .snapshot_i  (snapshot),
    .cyc_count_i (cyc_q),
    .tx_full_i   (uartTxFull),
    .wr_o        (writeFifoFlag),
    .data_o      (dataToUartOutFifo),
    .done_o      (tx_done)
  );

endmodule

// File: tb/tb_debug_unit_frame.sv
// Bench for debug_unit_frame: a 4-byte-snapshot / 2-byte-counter instance for
// the main scenarios and a 1/1 instance for the minimal build and saturation.
module tb_debug_unit_frame;
  import debug_pkg::*;

  localparam int F = 1 + 2 + 4 + 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- main DUT ----------------
  logic        eop = 1'b0;
  logic [31:0] snap = '0;
  logic [7:0]  rx_data = '0;
  logic        rx_avail = 1'b0;
  logic        tx_full = 1'b0;
  logic        rd, wr, pipeEnable, pipeReset, ledIdle, ledCont, ledStep, ledSend;
  logic [7:0]  tx_data;
  state_e      dbg_state;

  debug_unit_frame #(.SNAP_BYTES(4), .CYC_BYTES(2)) dut (
    .clock(clock), .reset(reset), .endOfProgram(eop), .snapshot(snap),
    .uartFifoDataIn(rx_data), .uartDataAvailable(rx_avail), .uartTxFull(tx_full),
    .readFifoFlag(rd), .dataToUartOutFifo(tx_data), .writeFifoFlag(wr),
    .pipeEnable(pipeEnable), .pipeReset(pipeReset), .ledIdle(ledIdle),
    .ledCont(ledCont), .ledStep(ledStep), .ledSend(ledSend), .dbgState(dbg_state)
  );

  // ---------------- small DUT ----------------
  logic       s_eop = 1'b0;
  logic [7:0] s_snap = '0;
  logic [7:0] s_rx_data = '0;
  logic       s_rx_avail = 1'b0;
  logic       s_tx_full = 1'b0;
  logic       s_rd, s_wr, s_pe, s_pr, s_idle, s_cont, s_step, s_send;
  logic [7:0] s_tx_data;
  state_e     s_dbg_state;

  debug_unit_frame #(.SNAP_BYTES(1), .CYC_BYTES(1)) dut_s (
    .clock(clock), .reset(reset), .endOfProgram(s_eop), .snapshot(s_snap),
    .uartFifoDataIn(s_rx_data), .uartDataAvailable(s_rx_avail), .uartTxFull(s_tx_full),
    .readFifoFlag(s_rd), .dataToUartOutFifo(s_tx_data), .writeFifoFlag(s_wr),
    .pipeEnable(s_pe), .pipeReset(s_pr), .ledIdle(s_idle),
    .ledCont(s_cont), .ledStep(s_step), .ledSend(s_send), .dbgState(s_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] s_got_q[$];
  int tests = 0;
  int fails = 0;
  int pop_cnt = 0;
  int en_cnt = 0;
  int bp_mode = 0;   // 0: never full, 1: toggle each cycle, 2: random
  int m_cnt = 0;

  // Monitor: record pushes, pops and enabled cycles away from the clock edge.
  always @(negedge clock) begin
    if (wr) got_q.push_back(tx_data);
    if (s_wr) s_got_q.push_back(s_tx_data);
    if (rd) pop_cnt++;
    if (pipeEnable) en_cnt++;
  end

  // Tx back-pressure driver.
  initial begin
    forever begin
      @(posedge clock); #1;
      if (bp_mode == 0)      tx_full = 1'b0;
      else if (bp_mode == 1) tx_full = ~tx_full;
      else                   tx_full = 1'($urandom_range(0, 1));
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Expected frame from the counter value (saturated to the counter width)
  // and the snapshot captured at the stop.
  function automatic void model_frame(input int cyc_b, input int snap_b,
                                      input longint cnt, input logic [31:0] sv);
    longint     cmax;
    longint     c;
    logic [7:0] b;
    logic [7:0] x;
    cmax = (longint'(1) << (8 * cyc_b)) - 1;
    c = (cnt > cmax) ? cmax : cnt;
    x = 8'h00;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < cyc_b; k++) begin
      b = 8'((c >> (8 * k)) & 255);
      exp_q.push_back(b);
      x = x ^ b;
    end
    for (int k = 0; k < snap_b; k++) begin
      b = 8'((sv >> (8 * k)) & 32'hFF);
      exp_q.push_back(b);
      x = x ^ b;
    end
    exp_q.push_back(x);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_avail = 1'b1;
    rx_data  = b;
    tick();
    rx_avail = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      @(posedge clock); #2;
      k++;
    end
    ok = (got_q.size() >= n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tests++;
    if ({pipeReset, pipeEnable, wr, rd, ledIdle, ledCont, ledStep, ledSend} !== 8'b1000_1000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, expected 10001000",
               {pipeReset, pipeEnable, wr, rd, ledIdle, ledCont, ledStep, ledSend});
    end
    tests++;
    if (tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_data: got %02h, expected 00", tx_data);
    end
    tests++;
    if ({s_pr, s_pe, s_wr, s_rd, s_idle, s_cont, s_step, s_send} !== 8'b1000_1000) begin
      fails++;
      $display("FAIL reset_small: got %b, expected 10001000",
               {s_pr, s_pe, s_wr, s_rd, s_idle, s_cont, s_step, s_send});
    end
  endtask

  // Step mode: several 'n' advances (with stray bytes), then 'q'.
  task automatic test_step(input int bp, input bit fixed_first);
    int         e0;
    int         n_adv;
    bit         ok;
    bit         quit;
    logic [5:0] st;
    logic [5:0] st_exp;
    bp_mode = bp;
    n_adv = 0;
    e0 = en_cnt;
    m_cnt = 0;
    send_byte(DEF_CMD_STEP);
    st = {ledIdle, ledCont, ledStep, ledSend, pipeReset, pipeEnable};
    tests++;
    if (st !== 6'b001000) begin
      fails++;
      $display("FAIL step_enter: got %b, expected 001000", st);
    end
    for (int it = 0; it < 4; it++) begin
      quit = (it == 3);
      snap = (fixed_first && it == 0) ? 32'h11223344 : $urandom;
      if (it == 2) send_byte(8'h78);
      if (quit) send_byte(DEF_CMD_ABORT);
      else begin
        send_byte(DEF_CMD_NEXT);
        m_cnt++;
        n_adv++;
      end
      model_frame(2, 4, m_cnt, snap);
      wait_bytes(1, 200, ok);
      snap = $urandom;
      if (ok) wait_bytes(F, 200, ok);
      tests++;
      if (!ok || got_q.size() != exp_q.size()) begin
        fails++;
        $display("FAIL step_len[%0d]: got %0d bytes, expected %0d", it, got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
        tests++;
        if (got_q[k] !== exp_q[k]) begin
          fails++;
          $display("FAIL step_byte[%0d][%0d]: got %02h, expected %02h", it, k, got_q[k], exp_q[k]);
        end
      end
      st = {ledIdle, ledCont, ledStep, ledSend, pipeReset, pipeEnable};
      st_exp = quit ? 6'b100010 : 6'b001000;
      tests++;
      if (st !== st_exp) begin
        fails++;
        $display("FAIL step_after[%0d]: got %b, expected %b", it, st, st_exp);
      end
      got_q.delete();
      exp_q.delete();
    end
    tests++;
    if (en_cnt - e0 != n_adv) begin
      fails++;
      $display("FAIL step_en_cycles: got %0d, expected %0d", en_cnt - e0, n_adv);
    end
  endtask

  task automatic test_idle_discard();
    int p0;
    p0 = pop_cnt;
    send_byte(8'h78);
    tests++;
    if (pop_cnt - p0 != 1 || ledIdle !== 1'b1 || pipeReset !== 1'b1) begin
      fails++;
      $display("FAIL idle_discard: got pops %0d idle %b reset %b, expected 1 1 1",
               pop_cnt - p0, ledIdle, pipeReset);
    end
  endtask

  // Continuous runs ending on endOfProgram, abort, or both together.
  task automatic test_cont();
    int         e0;
    int         p0;
    int         n;
    int         exp_pops;
    bit         ok;
    logic [5:0] st;
    for (int r = 0; r < 4; r++) begin
      bp_mode = (r == 0) ? 0 : 2;
      send_byte(DEF_CMD_CONT);
      e0 = en_cnt;
      p0 = pop_cnt;
      snap = $urandom;
      n = (r == 0) ? 10 : $urandom_range(4, 40);
      for (int c = 1; c < n; c++) begin
        if (r == 2 && c >= n - 2) begin
          rx_avail = 1'b1;
          rx_data  = 8'h78;
        end else begin
          rx_avail = 1'b0;
        end
        tick();
      end
      rx_avail = (r >= 2);
      rx_data  = DEF_CMD_ABORT;
      eop      = (r != 2);
      tick();
      rx_avail = 1'b0;
      eop      = 1'b0;
      tests++;
      if (pipeEnable !== 1'b0) begin
        fails++;
        $display("FAIL cont_stop[%0d]: pipeEnable got %b, expected 0", r, pipeEnable);
      end
      tests++;
      if (en_cnt - e0 != n) begin
        fails++;
        $display("FAIL cont_en_cycles[%0d]: got %0d, expected %0d", r, en_cnt - e0, n);
      end
      exp_pops = (r == 2) ? 3 : ((r == 3) ? 1 : 0);
      tests++;
      if (pop_cnt - p0 != exp_pops) begin
        fails++;
        $display("FAIL cont_pops[%0d]: got %0d, expected %0d", r, pop_cnt - p0, exp_pops);
      end
      model_frame(2, 4, n, snap);
      wait_bytes(1, 200, ok);
      snap = $urandom;
      if (ok) wait_bytes(F, 200, ok);
      tests++;
      if (!ok || got_q.size() != exp_q.size()) begin
        fails++;
        $display("FAIL cont_len[%0d]: got %0d bytes, expected %0d", r, got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
        tests++;
        if (got_q[k] !== exp_q[k]) begin
          fails++;
          $display("FAIL cont_byte[%0d][%0d]: got %02h, expected %02h", r, k, got_q[k], exp_q[k]);
        end
      end
      st = {ledIdle, ledCont, ledStep, ledSend, pipeReset, pipeEnable};
      tests++;
      if (st !== 6'b100010) begin
        fails++;
        $display("FAIL cont_after[%0d]: got %b, expected 100010", r, st);
      end
      got_q.delete();
      exp_q.delete();
    end
  endtask

  // Reset while byte 3 of a frame is on the tx port, then a fresh step frame.
  task automatic test_reset_mid_frame();
    bit         ok;
    logic [5:0] st;
    bp_mode = 0;
    snap = $urandom;
    send_byte(DEF_CMD_STEP);
    send_byte(DEF_CMD_NEXT);
    model_frame(2, 4, 1, snap);
    wait_bytes(3, 200, ok);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    st = {ledIdle, ledCont, ledStep, ledSend, pipeReset, pipeEnable};
    tests++;
    if (wr !== 1'b0 || st !== 6'b100010) begin
      fails++;
      $display("FAIL rstmid_ctrl: got wr %b leds %b, expected 0 100010", wr, st);
    end
    repeat (5) tick();
    tests++;
    if (!ok || got_q.size() != 4) begin
      fails++;
      $display("FAIL rstmid_count: got %0d bytes, expected 4", got_q.size());
    end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      tests++;
      if (got_q[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL rstmid_byte[%0d]: got %02h, expected %02h", k, got_q[k], exp_q[k]);
      end
    end
    got_q.delete();
    exp_q.delete();
    snap = $urandom;
    send_byte(DEF_CMD_STEP);
    send_byte(DEF_CMD_NEXT);
    model_frame(2, 4, 1, snap);
    wait_bytes(F, 200, ok);
    tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL rstmid_fresh_len: got %0d bytes, expected %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      tests++;
      if (got_q[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL rstmid_fresh_byte[%0d]: got %02h, expected %02h", k, got_q[k], exp_q[k]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Minimal build: 300 enabled cycles must saturate a one-byte counter.
  task automatic test_saturation();
    int budget;
    s_snap = 8'($urandom);
    s_rx_avail = 1'b1;
    s_rx_data  = DEF_CMD_CONT;
    tick();
    s_rx_avail = 1'b0;
    repeat (299) tick();
    s_eop = 1'b1;
    tick();
    s_eop = 1'b0;
    model_frame(1, 1, 300, {24'h0, s_snap});
    budget = 0;
    while (s_got_q.size() < 4 && budget < 100) begin
      @(posedge clock); #2;
      budget++;
    end
    tests++;
    if (s_got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL sat_len: got %0d bytes, expected %0d", s_got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < s_got_q.size(); k++) begin
      tests++;
      if (s_got_q[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL sat_byte[%0d]: got %02h, expected %02h", k, s_got_q[k], exp_q[k]);
      end
    end
    tests++;
    if (s_idle !== 1'b1 || s_pr !== 1'b1) begin
      fails++;
      $display("FAIL sat_after: got idle %b reset %b, expected 1 1", s_idle, s_pr);
    end
    s_got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_step(0, 1'b1);
    test_step(1, 1'b0);
    test_idle_discard();
    test_cont();
    test_reset_mid_frame();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debug_unit_frame.md
Name: debug_unit_frame

Overview:
Parametrised successor debug controller for the pipelined MIPS datapath, sitting between the UART rx/tx FIFOs and the pipeline enable/reset controls. It runs the pipeline in continuous or single-step mode under UART command control. After each stop it sends a framed, checksummed snapshot of a generic-width pipeline-state bus plus an executed-cycle count. New over the previous generation: generic snapshot width, snapshot latching, tx back-pressure, cycle counter, checksum, and an abort command.

Parameters:
SNAP_BYTES, 55, number of snapshot bytes on the snapshot bus (≥1).
CYC_BYTES, 2, width in bytes of the executed-cycle counter (1..4).
HEADER, 8'hA5, first byte of every frame.
CMD_CONT, 8'h63, 'c' starts continuous run.
CMD_STEP, 8'h73, 's' starts step mode.
CMD_NEXT, 8'h6E, 'n' advances one cycle in step mode.
CMD_ABORT, 8'h71, 'q' aborts the run.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
endOfProgram  in  1  pipeline has fetched the halt condition
snapshot  in  SNAP_BYTES*8  flattened pipeline-register state; byte k = bits [8k+7:8k]
uartFifoDataIn  in  8  rx FIFO head byte
uartDataAvailable  in  1  rx FIFO not empty
uartTxFull  in  1  tx FIFO full
readFifoFlag  out  1  pop rx FIFO this cycle
dataToUartOutFifo  out  8  byte to push
writeFifoFlag  out  1  push tx FIFO this cycle
pipeEnable  out  1  pipeline clock-enable
pipeReset  out  1  pipeline reset
ledIdle, ledCont, ledStep, ledSend  out  1 each  one-hot state indication

Behaviour:
- Reset: on a clock edge with reset=1, state←IDLE, byte index←0, cycle counter←0, done flag←0, snapshot latch←0. In the following cycle: pipeReset=1, pipeEnable=0, writeFifoFlag=0, readFifoFlag=0, dataToUartOutFifo=0, ledIdle=1, other LEDs 0. Reset mid-frame truncates the frame; no further bytes are pushed.
- States: IDLE, CONT, STEP, ADVANCE, CAPTURE, SEND. All outputs are decoded combinationally from registered state, index and FIFO flags. No latches: every output has a default.
- IDLE:
  - pipeReset=1, pipeEnable=0; cycle counter and done flag held at 0.
  - When uartDataAvailable=1: readFifoFlag=1 for that cycle, and the byte is consumed.
  - CMD_CONT→CONT; CMD_STEP→STEP; any other byte is discarded and the state stays IDLE.
- CONT:
  - pipeEnable=1, pipeReset=0; ledCont=1.
  - Rx bytes are popped: CMD_ABORT sets done and goes to CAPTURE; other bytes are discarded.
  - endOfProgram=1 sets done and goes to CAPTURE.
  - If abort and endOfProgram occur in the same cycle, the result is the same: done, then CAPTURE.
- STEP:
  - pipeEnable=0, pipeReset=0; ledStep=1.
  - Rx bytes are popped: CMD_NEXT→ADVANCE; CMD_ABORT sets done and goes to CAPTURE; others are discarded.
- ADVANCE: exactly one cycle with pipeEnable=1, then CAPTURE. endOfProgram=1 in this cycle sets done.
- CAPTURE:
  - One cycle, pipeEnable=0. The snapshot latch loads the snapshot bus at the end of this cycle, i.e. the state after the last enabled edge.
  - Byte index←0, checksum←0, then SEND.
- SEND:
  - ledSend=1, pipeEnable=0; rx is not read.
  - Frame length F = 1+CYC_BYTES+SNAP_BYTES+1. Byte order:
    - HEADER;
    - cycle counter, LSB first;
    - latched snapshot, byte 0 first;
    - checksum = XOR of all bytes after HEADER.
  - writeFifoFlag=1 only when uartTxFull=0. The index and checksum advance only on a push.
  - While uartTxFull=1, the current byte is held and writeFifoFlag=0.
  - After pushing byte F-1: if done→IDLE, else→STEP.
- Cycle counter: increments on every cycle with pipeEnable=1 and saturates at all-ones (no wrap). It is cleared only in IDLE or on reset.
- Index width is clog2(F+1). SNAP_BYTES=1 and CYC_BYTES=1 must work.
- Continuous mode over the rx path is one byte per cycle; back-to-back commands are each consumed on consecutive cycles.

Decomposition:
- debug_pkg: state enum, command-byte defaults, HEADER default, and a frame-length function.
- One sub-module, debug_frame_tx: serialiser holding the snapshot latch, index, checksum and tx handshake. Its interface is start, done pulse, snapshot, cycle count and the tx FIFO signals.

Test Plan:
- Step run, SNAP_BYTES=4, snapshot=32'h11223344, send 's','n' with tx never full → exactly one pipeEnable cycle, then frame A5,01,00,44,33,22,11,checksum=01^00^44^33^22^11=0x45; returns to STEP.
- Continuous run: 'c', endOfProgram asserted after 10 enabled cycles → counter bytes 0A,00; after the frame, state is IDLE and pipeReset=1.
- Back-pressure: uartTxFull toggles 1/0 every cycle during SEND → F pushes total, no byte duplicated or skipped, byte order preserved.
- Abort: 'q' in STEP → CAPTURE, SEND, then IDLE; 'q' in CONT stops pipeEnable the next cycle; the IDLE-time byte 'x' is popped and ignored.
- Reset asserted at byte index 3 of SEND → writeFifoFlag=0 from the next cycle, LEDs back to idle, counter 0; a following 's','n' produces a complete fresh frame.
- Saturation: CYC_BYTES=1, 300 enabled cycles in CONT → counter byte FF.
